// File: rtl/branch_predictor.sv
// branch_predictor: 2-bit saturating counter direction predictor with training and mispredict statistics
module branch_predictor #(
  parameter int INDEX_BITS = 6,
  parameter int PC_WIDTH   = 32,
  parameter int CNT_WIDTH  = 32
) (
  input  logic                 clk,
  input  logic                 reset,
  input  logic [PC_WIDTH-1:0]  fetch_pc,
  output logic                 predict_taken,
  input  logic                 resolve_valid,
  input  logic [PC_WIDTH-1:0]  resolve_pc,
  input  logic                 resolve_taken,
  input  logic                 resolve_predicted,
  output logic                 mispredict,
  output logic [CNT_WIDTH-1:0] branch_count,
  output logic [CNT_WIDTH-1:0] mispredict_count
);
  localparam int ENTRIES = 1 << INDEX_BITS;
  logic [1:0] tbl [ENTRIES];
  logic [INDEX_BITS-1:0] fetch_idx, resolve_idx;
  logic [1:0] cur, nxt;
  assign fetch_idx   = fetch_pc[INDEX_BITS+1:2];
  assign resolve_idx = resolve_pc[INDEX_BITS+1:2];
  // lookup reads the stored entry, so a same-cycle update shows only after the edge
  always_comb begin
    cur           = tbl[resolve_idx];
    nxt           = resolve_taken ? ((cur == 2'd3) ? cur : cur + 2'd1) : ((cur == 2'd0) ? cur : cur - 2'd1);
    predict_taken = tbl[fetch_idx][1];
    mispredict    = resolve_valid & (resolve_taken ^ resolve_predicted);
  end
  // table training and saturating statistics; reset wins over any resolve
  always_ff @(posedge clk) begin
    if (reset) begin
      for (int i = 0; i < ENTRIES; i++) tbl[i] <= 2'd1;
      branch_count     <= '0;
      mispredict_count <= '0;
    end else if (resolve_valid) begin
      tbl[resolve_idx] <= nxt;
      branch_count     <= &branch_count ? branch_count : branch_count + CNT_WIDTH'(1);
      if (mispredict) mispredict_count <= &mispredict_count ? mispredict_count : mispredict_count + CNT_WIDTH'(1);
    end
  end
endmodule

// File: tb/tb_branch_predictor.sv
// tb_branch_predictor: directed self-checking bench for branch_predictor
module tb_branch_predictor;
  logic        clk = 1'b0;
  logic        reset = 1'b0;
  logic [31:0] fetch_pc = '0;
  logic        resolve_valid = 1'b0;
  logic [31:0] resolve_pc = '0;
  logic        resolve_taken = 1'b0;
  logic        resolve_predicted = 1'b0;
  logic        predict_taken, mispredict;
  logic [31:0] branch_count, mispredict_count;
  logic        predict_taken4, mispredict4;
  logic [3:0]  branch_count4, mispredict_count4;
  int          n_cmp = 0;
  int          n_bad = 0;

  branch_predictor dut (
    .clk(clk), .reset(reset), .fetch_pc(fetch_pc), .predict_taken(predict_taken),
    .resolve_valid(resolve_valid), .resolve_pc(resolve_pc), .resolve_taken(resolve_taken),
    .resolve_predicted(resolve_predicted), .mispredict(mispredict),
    .branch_count(branch_count), .mispredict_count(mispredict_count)
  );

  branch_predictor #(.CNT_WIDTH(4)) dut4 (
    .clk(clk), .reset(reset), .fetch_pc(fetch_pc), .predict_taken(predict_taken4),
    .resolve_valid(resolve_valid), .resolve_pc(resolve_pc), .resolve_taken(resolve_taken),
    .resolve_predicted(resolve_predicted), .mispredict(mispredict4),
    .branch_count(branch_count4), .mispredict_count(mispredict_count4)
  );

  always #5 clk = ~clk;

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic check_counts(input string name, input int eb, input int em);
    n_cmp++;
    if (branch_count !== 32'(eb)) begin
      n_bad++;
      $display("FAIL %s branch_count got %0d want %0d", name, branch_count, eb);
    end
    n_cmp++;
    if (mispredict_count !== 32'(em)) begin
      n_bad++;
      $display("FAIL %s mispredict_count got %0d want %0d", name, mispredict_count, em);
    end
  endtask

  task automatic check_pred(input string name, input logic [31:0] pc, input logic exp);
    fetch_pc = pc;
    #1;
    n_cmp++;
    if (predict_taken !== exp) begin
      n_bad++;
      $display("FAIL %s predict_taken@%h got %b want %b", name, pc, predict_taken, exp);
    end
  endtask

  task automatic test_reset();
    reset = 1'b1;
    step();
    reset = 1'b0;
    for (int i = 0; i < 64; i++) check_pred("reset_sweep", 32'(i * 4), 1'b0);
    check_counts("reset", 0, 0);
  endtask

  task automatic test_train();
    logic exp_pred [5] = '{1'b1, 1'b1, 1'b1, 1'b1, 1'b0};
    for (int k = 0; k < 5; k++) begin
      resolve_valid     = 1'b1;
      resolve_pc        = 32'h40;
      resolve_taken     = (k < 3);
      resolve_predicted = (k >= 3);
      #1;
      n_cmp++;
      if (mispredict !== 1'b1) begin
        n_bad++;
        $display("FAIL train_mispredict[%0d] got %b want 1", k, mispredict);
      end
      step();
      resolve_valid = 1'b0;
      check_pred("train", 32'h40, exp_pred[k]);
    end
    check_counts("train", 5, 5);
  endtask

  task automatic test_alias();
    for (int k = 0; k < 2; k++) begin
      resolve_valid     = 1'b1;
      resolve_pc        = 32'h40;
      resolve_taken     = 1'b1;
      resolve_predicted = 1'b1;
      #1;
      n_cmp++;
      if (mispredict !== 1'b0) begin
        n_bad++;
        $display("FAIL alias_mispredict[%0d] got %b want 0", k, mispredict);
      end
      step();
    end
    resolve_valid = 1'b0;
    check_pred("alias", 32'h140, 1'b1);
    check_pred("alias_neighbor_hi", 32'h44, 1'b0);
    check_pred("alias_neighbor_lo", 32'h3C, 1'b0);
    check_pred("alias_offset_bits", 32'h43, 1'b1);
    check_counts("alias", 7, 5);
  endtask

  task automatic test_hazard();
    fetch_pc          = 32'h80;
    resolve_valid     = 1'b1;
    resolve_pc        = 32'h80;
    resolve_taken     = 1'b1;
    resolve_predicted = 1'b0;
    #1;
    n_cmp++;
    if (predict_taken !== 1'b0) begin
      n_bad++;
      $display("FAIL hazard_same_cycle got %b want 0", predict_taken);
    end
    step();
    resolve_valid = 1'b0;
    check_pred("hazard_next_cycle", 32'h80, 1'b1);
    check_counts("hazard", 8, 6);
  endtask

  task automatic test_reset_mid();
    reset             = 1'b1;
    resolve_valid     = 1'b1;
    resolve_pc        = 32'h40;
    resolve_taken     = 1'b1;
    resolve_predicted = 1'b0;
    step();
    reset         = 1'b0;
    resolve_valid = 1'b0;
    check_pred("reset_mid_40", 32'h40, 1'b0);
    check_pred("reset_mid_80", 32'h80, 1'b0);
    check_counts("reset_mid", 0, 0);
    resolve_valid = 1'b1;
    step();
    resolve_valid = 1'b0;
    check_pred("reset_mid_entry_is_weak", 32'h40, 1'b1);
    check_counts("reset_mid_after", 1, 1);
  endtask

  task automatic test_saturation();
    reset = 1'b1;
    step();
    reset = 1'b0;
    for (int k = 1; k <= 20; k++) begin
      resolve_valid     = 1'b1;
      resolve_pc        = 32'hC0;
      resolve_taken     = 1'b1;
      resolve_predicted = 1'b0;
      step();
      n_cmp++;
      if (branch_count4 !== 4'((k > 15) ? 15 : k) || mispredict_count4 !== 4'((k > 15) ? 15 : k)) begin
        n_bad++;
        $display("FAIL sat4[%0d] counts got %0d/%0d want %0d", k, branch_count4, mispredict_count4, (k > 15) ? 15 : k);
      end
    end
    check_counts("sat32", 20, 20);
    for (int k = 0; k < 3; k++) begin
      resolve_valid     = 1'b0;
      resolve_pc        = 32'hC0;
      resolve_taken     = k[0];
      resolve_predicted = ~k[0];
      #1;
      n_cmp++;
      if (mispredict !== 1'b0) begin
        n_bad++;
        $display("FAIL idle_mispredict[%0d] got %b want 0", k, mispredict);
      end
      step();
    end
    check_counts("idle", 20, 20);
    n_cmp++;
    if (branch_count4 !== 4'd15 || mispredict_count4 !== 4'd15) begin
      n_bad++;
      $display("FAIL idle_sat4 counts got %0d/%0d want 15/15", branch_count4, mispredict_count4);
    end
    check_pred("idle_entry", 32'hC0, 1'b1);
  endtask

  task automatic test_back_to_back();
    reset = 1'b1;
    step();
    reset = 1'b0;
    resolve_valid     = 1'b1;
    resolve_pc        = 32'h10;
    resolve_taken     = 1'b1;
    resolve_predicted = 1'b0;
    step();
    resolve_pc = 32'h14;
    step();
    resolve_pc    = 32'h10;
    resolve_taken = 1'b0;
    step();
    resolve_valid = 1'b0;
    check_pred("b2b_10", 32'h10, 1'b0);
    check_pred("b2b_14", 32'h14, 1'b1);
    check_counts("b2b", 3, 2);
  endtask

  initial begin
    test_reset();
    test_train();
    test_alias();
    test_hazard();
    test_reset_mid();
    test_saturation();
    test_back_to_back();
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end
endmodule

// File: doc/branch_predictor.md
# branch_predictor

Dynamic branch predictor for the MIPS pipeline. The fetch stage looks up a direction prediction for the current PC in a table of 2-bit saturating counters. The branch tester in execute later produces the resolved `branch` outcome, which is fed back here to train the table, flag mispredictions and keep performance counters. The block closes the loop between fetch-time speculation and execute-time branch resolution.

## Interface
Parameters:
- `INDEX_BITS`, 6, log2 of table entries (64 entries)
- `PC_WIDTH`, 32, width of PC inputs
- `CNT_WIDTH`, 32, width of the statistics counters

Ports:
- `clk`  input  1  clock; all state updates on its rising edge
- `reset`  input  1  synchronous, active-high reset
- `fetch_pc`  input  PC_WIDTH  PC of the instruction in fetch
- `predict_taken`  output  1  prediction for `fetch_pc`; combinational from table
- `resolve_valid`  input  1  a branch instruction is resolving in execute this cycle
- `resolve_pc`  input  PC_WIDTH  PC of the resolving branch
- `resolve_taken`  input  1  actual outcome (branch tester `branch` output)
- `resolve_predicted`  input  1  prediction carried down the pipeline with that branch
- `mispredict`  output  1  combinational: `resolve_valid & (resolve_taken != resolve_predicted)`
- `branch_count`  output  CNT_WIDTH  registered count of resolved branches
- `mispredict_count`  output  CNT_WIDTH  registered count of mispredictions

## Operation
- Table: 2^INDEX_BITS entries, 2 bits each. States: 0 strong-not-taken, 1 weak-not-taken, 2 weak-taken, 3 strong-taken.
- Index is `pc[INDEX_BITS+1:2]` for both lookup and update. The word-offset bits [1:0] are ignored. No tags: aliasing is allowed.
- Lookup: `predict_taken` = MSB of the entry selected by `fetch_pc`. Purely combinational; available in the same cycle.
- Update, on a clock edge when `resolve_valid=1`:
  - `resolve_taken=1`: entry at `resolve_pc` increments, saturating at 3.
  - `resolve_taken=0`: entry decrements, saturating at 0.
- When `resolve_valid=0`: no table change, no counter change. `resolve_*` values are don't-care.
- `branch_count` increments on every `resolve_valid` cycle.
- `mispredict_count` increments when `mispredict=1`.
- Both counters saturate at all-ones; they never wrap.
- `mispredict` depends only on the resolve inputs. It does not depend on the current table contents.

## Timing
- Reset, synchronous: on the first edge with `reset=1`:
  - every table entry becomes 1 (weak-not-taken);
  - `branch_count` and `mispredict_count` become 0.
- After reset, `predict_taken` reads 0 for every PC. `mispredict` stays combinational and is not gated by reset.
- `reset` has priority over any simultaneous update. A resolve presented on a reset edge is discarded and not counted.
- Update latency is one cycle: an update at edge N is visible on `predict_taken` from just after edge N.
- Same-cycle lookup and update to the same index: `predict_taken` shows the pre-update value (read-before-write). The new value appears in the next cycle.
- One update per cycle maximum. No stall or back-pressure signals.

## Test plan
- Reset, then sweep `fetch_pc` over 0x0–0xFC in steps of 4 -> `predict_taken=0` for all 64 entries; both counts read 0.
- Three taken resolves at `resolve_pc=0x40` with `resolve_predicted=0`, then two not-taken with `resolve_predicted=1`:
  - prediction at 0x40 after each edge is 1,1,1 then 1,0 (entry goes 1→2→3→3, then 2→1);
  - `mispredict` asserts on all 5 resolves;
  - `branch_count=5`, `mispredict_count=5`.
- Aliasing: train 0x40 taken twice, then look up 0x140 with INDEX_BITS=6 -> `predict_taken=1`. Entries at 0x44 and 0x3C remain 0.
- Same-cycle hazard: `fetch_pc=resolve_pc=0x80`, entry=1, taken resolve -> `predict_taken=0` in that cycle, 1 in the next cycle.
- Reset mid-operation: assert `reset` together with a `resolve_valid` taken resolve on a trained entry -> entry returns to 1 and counts return to 0; the resolve is not counted.
- Saturation: CNT_WIDTH=4, 20 mispredicted resolves -> both counts hold at 15. `resolve_valid=0` cycles change nothing.
